ram_clr: RTL and testbench



---
 rtl/ram_clr_if.sv | 24 ++
 rtl/ram_clr.sv | 87 ++++++++
 tb/tb_ram_clr.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_clr_if.sv
// Bus bundle for ram_clr: write data/enable, address, clear request and
// the read/status returns. Clock and reset stay as plain module ports.
interface ram_clr_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 9
);
    logic [WIDTH-1:0]  in_i;
    logic              load_i;
    logic [ADDR_W-1:0] address_i;
    logic              clear_i;
    logic [WIDTH-1:0]  out_o;
    logic              busy_o;
    logic              wr_dropped_o;

    modport master (
        output in_i, load_i, address_i, clear_i,
        input  out_o, busy_o, wr_dropped_o
    );

    modport slave (
        input  in_i, load_i, address_i, clear_i,
        output out_o, busy_o, wr_dropped_o
    );
endinterface

// File: rtl/ram_clr.sv
// Parametrised Hack-style RAM with combinational read and a hardware
// clear sequencer that zeroes every word after reset or on request.
module ram_clr #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic     clk_i,
    input  logic     rst_n_i,
    ram_clr_if.slave bus
);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              wr_dropped;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic addr_ok;
    logic wr_ok;
    logic drop_next;

    // Address range decode and write accept/reject decisions.
    always_comb begin
        addr_ok   = ({1'b0, bus.address_i} < DEPTH_L);
        wr_ok     = (state == IDLE) && bus.load_i && !bus.clear_i && addr_ok;
        drop_next = bus.load_i && ((state == CLEAR) || bus.clear_i || !addr_ok);
    end

    // Clear sequencer FSM with the registered dropped-write pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            wr_dropped <= 1'b0;
        end else begin
            wr_dropped <= drop_next;
            case (state)
                CLEAR: begin
                    if (clr_cnt == LAST) begin
                        state   <= IDLE;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.clear_i) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_cnt <= '0;
                end
            endcase
        end
    end

    // Array write port: the clear sweep owns the array while it runs.
    always_ff @(posedge clk_i) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (wr_ok) begin
            mem[bus.address_i] <= bus.in_i;
        end
    end

    // Combinational read and status outputs.
    always_comb begin
        bus.out_o        = '0;
        if ((state == IDLE) && addr_ok) begin
            bus.out_o = mem[bus.address_i];
        end
        bus.busy_o       = (state == CLEAR);
        bus.wr_dropped_o = wr_dropped;
    end

endmodule

// File: tb/tb_ram_clr.sv
// Directed self-checking bench for ram_clr: a 16x512 instance and a
// 16x384 instance (non-power-of-two depth) sharing clock and reset.
module tb_ram_clr;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [15:0] exp [512];

    ram_clr_if #(.WIDTH(16), .ADDR_W(9)) if1 ();
    ram_clr_if #(.WIDTH(16), .ADDR_W(9)) if2 ();

    ram_clr #(.WIDTH(16), .DEPTH(512), .ADDR_W(9)) u_dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (if1.slave)
    );

    ram_clr #(.WIDTH(16), .DEPTH(384), .ADDR_W(9)) u_dut384 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (if2.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write1(input logic [8:0] a, input logic [15:0] d);
        if1.address_i = a;
        if1.in_i      = d;
        if1.load_i    = 1'b1;
        tick();
        if1.load_i    = 1'b0;
        exp[a]        = d;
    endtask

    task automatic test_reset();
        if1.in_i = 16'hFFFF; if1.load_i = 1'b1; if1.address_i = 9'h0AA; if1.clear_i = 1'b0;
        if2.in_i = '0;       if2.load_i = 1'b0; if2.address_i = '0;     if2.clear_i = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (if1.busy_o !== 1'b1 || if1.out_o !== 16'h0 || if1.wr_dropped_o !== 1'b0)
            $display("FAIL reset_state: busy=%b out=%h drop=%b, want 1 0000 0", if1.busy_o, if1.out_o, if1.wr_dropped_o);
        else pass_cnt++;
        tick(); tick();
        #3 rst_n = 1'b1;
    endtask

    task automatic test_power_on_sweep();
        int busy_edges = 0;
        int drops = 0;
        int bad = 0;
        for (int i = 0; i < 520; i++) begin
            if (if1.busy_o === 1'b1) busy_edges++;
            tick();
            if (if1.wr_dropped_o === 1'b1) drops++;
        end
        if1.load_i = 1'b0;
        total_cnt++;
        if (busy_edges !== 512) $display("FAIL sweep_busy_edges: got %0d want 512", busy_edges);
        else pass_cnt++;
        total_cnt++;
        if (drops !== 512) $display("FAIL sweep_drops: got %0d want 512", drops);
        else pass_cnt++;
        for (int a = 0; a < 512; a++) exp[a] = 16'h0;
        exp[9'h0AA] = 16'hFFFF;
        for (int a = 0; a < 512; a++) begin
            if1.address_i = 9'(a);
            #1;
            if (if1.out_o !== exp[a]) bad++;
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL sweep_contents: %0d words wrong, want 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_write_read();
        int bad = 0;
        write1(9'h049, 16'h8285);
        write1(9'h092, 16'hFEB9);
        write1(9'h0DB, 16'h2B67);
        write1(9'h1FF, 16'h3039);
        total_cnt++;
        if (if1.wr_dropped_o !== 1'b0) $display("FAIL valid_write_drop: got %b want 0", if1.wr_dropped_o);
        else pass_cnt++;
        if1.address_i = 9'h0DB;
        #1;
        total_cnt++;
        if (if1.out_o !== 16'h2B67) $display("FAIL comb_read_0DB: got %h want 2b67", if1.out_o);
        else pass_cnt++;
        if1.address_i = 9'h1FF;
        #1;
        total_cnt++;
        if (if1.out_o !== 16'h3039) $display("FAIL comb_read_1FF: got %h want 3039", if1.out_o);
        else pass_cnt++;
        for (int a = 0; a < 512; a++) begin
            if1.address_i = 9'(a);
            #1;
            if (if1.out_o !== exp[a]) bad++;
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL write_sweep: %0d words wrong, want 0", bad);
        else pass_cnt++;
        // read-during-write: old word before the edge, new word after
        if1.address_i = 9'h049; if1.in_i = 16'h5A5A; if1.load_i = 1'b1;
        #1;
        total_cnt++;
        if (if1.out_o !== 16'h8285) $display("FAIL rdw_old: got %h want 8285", if1.out_o);
        else pass_cnt++;
        tick();
        if1.load_i = 1'b0;
        exp[9'h049] = 16'h5A5A;
        total_cnt++;
        if (if1.out_o !== 16'h5A5A) $display("FAIL rdw_new: got %h want 5a5a", if1.out_o);
        else pass_cnt++;
    endtask

    task automatic test_clear_request();
        int n = 0;
        int nz = 0;
        write1(9'h16D, 16'd33);
        if1.address_i = 9'h16D;
        #1;
        total_cnt++;
        if (if1.out_o !== 16'd33) $display("FAIL pre_clear_read: got %h want 0021", if1.out_o);
        else pass_cnt++;
        if1.clear_i = 1'b1;
        tick();
        if1.clear_i = 1'b0;
        total_cnt++;
        if (if1.busy_o !== 1'b1) $display("FAIL clear_start_busy: got %b want 1", if1.busy_o);
        else pass_cnt++;
        while (if1.busy_o === 1'b1 && n < 600) begin
            if (if1.out_o !== 16'h0) nz++;
            if1.clear_i = (n == 100);
            tick();
            n++;
        end
        if1.clear_i = 1'b0;
        total_cnt++;
        if (n !== 512) $display("FAIL clear_len: got %0d edges want 512", n);
        else pass_cnt++;
        total_cnt++;
        if (nz !== 0) $display("FAIL clear_out_zero: %0d nonzero reads want 0", nz);
        else pass_cnt++;
        for (int a = 0; a < 512; a++) exp[a] = 16'h0;
        #1;
        total_cnt++;
        if (if1.out_o !== 16'h0) $display("FAIL post_clear_16D: got %h want 0000", if1.out_o);
        else pass_cnt++;
    endtask

    task automatic test_clear_beats_load();
        int n = 0;
        write1(9'h124, 16'h7777);
        if1.address_i = 9'h124; if1.in_i = 16'h0001;
        if1.load_i = 1'b1; if1.clear_i = 1'b1;
        tick();
        if1.load_i = 1'b0; if1.clear_i = 1'b0;
        total_cnt++;
        if (if1.wr_dropped_o !== 1'b1) $display("FAIL clr_load_drop: got %b want 1", if1.wr_dropped_o);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (if1.wr_dropped_o !== 1'b0) $display("FAIL drop_one_cycle: got %b want 0", if1.wr_dropped_o);
        else pass_cnt++;
        n = 1;
        while (if1.busy_o === 1'b1 && n < 600) begin
            tick();
            n++;
        end
        total_cnt++;
        if (n !== 512) $display("FAIL clr_load_len: got %0d edges want 512", n);
        else pass_cnt++;
        exp[9'h124] = 16'h0;
        total_cnt++;
        if (if1.out_o !== 16'h0) $display("FAIL clr_load_word: got %h want 0000", if1.out_o);
        else pass_cnt++;
    endtask

    task automatic test_depth384();
        total_cnt++;
        if (if2.busy_o !== 1'b0) $display("FAIL d384_idle: busy=%b want 0", if2.busy_o);
        else pass_cnt++;
        if2.address_i = 9'h1B6; if2.in_i = 16'hF000; if2.load_i = 1'b1;
        tick();
        if2.load_i = 1'b0;
        total_cnt++;
        if (if2.wr_dropped_o !== 1'b1 || if2.out_o !== 16'h0)
            $display("FAIL d384_oor_1B6: drop=%b out=%h want 1 0000", if2.wr_dropped_o, if2.out_o);
        else pass_cnt++;
        if2.address_i = 9'h180; if2.in_i = 16'hBEEF; if2.load_i = 1'b1;
        tick();
        if2.load_i = 1'b0;
        total_cnt++;
        if (if2.wr_dropped_o !== 1'b1 || if2.out_o !== 16'h0)
            $display("FAIL d384_oor_180: drop=%b out=%h want 1 0000", if2.wr_dropped_o, if2.out_o);
        else pass_cnt++;
        if2.address_i = 9'h17F; if2.in_i = 16'h1234; if2.load_i = 1'b1;
        tick();
        if2.load_i = 1'b0;
        total_cnt++;
        if (if2.wr_dropped_o !== 1'b0 || if2.out_o !== 16'h1234)
            $display("FAIL d384_last_word: drop=%b out=%h want 0 1234", if2.wr_dropped_o, if2.out_o);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_clear();
        int n1 = 0;
        int n2 = 0;
        if1.clear_i = 1'b1;
        tick();
        if1.clear_i = 1'b0;
        for (int i = 0; i < 200; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (if1.busy_o !== 1'b1 || if1.out_o !== 16'h0)
            $display("FAIL midclear_reset: busy=%b out=%h want 1 0000", if1.busy_o, if1.out_o);
        else pass_cnt++;
        total_cnt++;
        if (if2.busy_o !== 1'b1 || if2.out_o !== 16'h0)
            $display("FAIL idle_reset_d384: busy=%b out=%h want 1 0000", if2.busy_o, if2.out_o);
        else pass_cnt++;
        tick(); tick();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (if1.busy_o === 1'b1) n1++;
            if (if2.busy_o === 1'b1) n2++;
            tick();
        end
        total_cnt++;
        if (n1 !== 512) $display("FAIL restart_len_512: got %0d edges want 512", n1);
        else pass_cnt++;
        total_cnt++;
        if (n2 !== 384) $display("FAIL restart_len_384: got %0d edges want 384", n2);
        else pass_cnt++;
        if2.address_i = 9'h17F;
        #1;
        total_cnt++;
        if (if2.out_o !== 16'h0) $display("FAIL d384_cleared_17F: got %h want 0000", if2.out_o);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_power_on_sweep();
        test_write_read();
        test_clear_request();
        test_clear_beats_load();
        test_depth384();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
